wb_data_ram: RTL and testbench

//  Pipelined Wishbone (B4) slave data memory. Sits directly downstream of the core's data Wishbone master port.

---
 rtl/wb_data_ram_pkg.sv | 13 +
 rtl/wb_data_ram_array.sv | 41 ++++
 rtl/wb_data_ram.sv | 113 +++++++++++
 tb/tb_wb_data_ram.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_data_ram_pkg.sv
// rtl/wb_data_ram_pkg.sv - shared types and constants for the Wishbone data RAM
package wb_data_ram_pkg;

   localparam int SEL_W = 4;
   localparam int DAT_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/wb_data_ram_array.sv
// rtl/wb_data_ram_array.sv - single-port word RAM with byte write enables and registered read
module wb_data_ram_array
   import wb_data_ram_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en_i,
   input  logic              we_i,
   input  logic [SEL_W-1:0]  sel_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DAT_W-1:0]  wdata_i,
   output logic [DAT_W-1:0]  rdata_o
);

   logic [DAT_W-1:0] mem [DEPTH];
   logic [DAT_W-1:0] rdata_q, rdata_d;

   // Read register holds its value until the next read so it survives wait states.
   always_comb begin
      rdata_d = rdata_q;
      if (en_i && !we_i) begin
         rdata_d = mem[addr_i];
      end
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
      if (en_i && we_i) begin
         for (int b = 0; b < SEL_W; b++) begin
            if (sel_i[b]) begin
               mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_data_ram.sv
// rtl/wb_data_ram.sv - pipelined Wishbone B4 slave data RAM with wait states and error response
// Define WB_RAM_WPROT_EN to reject writes below PROTECT_TOP.
module wb_data_ram
   import wb_data_ram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH       = 1024,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] PROTECT_TOP = 32'h0000_0100
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [DAT_W-1:0]  wb_dat_i,
   input  logic [SEL_W-1:0]  wb_sel_i,
   output logic              wb_stall_o,
   output logic              wb_ack_o,
   output logic [DAT_W-1:0]  wb_dat_o,
   output logic              wb_err_o
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [32:0] SPAN    = 33'(DEPTH) * 33'd4;
   localparam logic [2:0]  WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   state_e           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             we_q, we_d;
   logic             accept, out_of_range, prot_hit, req_err;
   logic [31:0]      offset;
   logic [DAT_W-1:0] rdata;

   assign offset       = wb_adr_i - BASE_ADDR;
   assign out_of_range = (wb_adr_i < BASE_ADDR) || ({1'b0, offset} >= SPAN);

`ifdef WB_RAM_WPROT_EN
   assign prot_hit = wb_we_i && (offset < PROTECT_TOP);
`else
   logic unused_prot;
   assign unused_prot = ^PROTECT_TOP;
   assign prot_hit    = 1'b0;
`endif

   assign req_err = out_of_range || prot_hit;
   assign accept  = wb_cyc_i && wb_stb_i && (state_q != ST_WAIT);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      we_d    = we_q;
      case (state_q)
         ST_WAIT: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 3'd0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A new request is taken in IDLE or in the response cycle of the previous one.
      if (accept) begin
         err_d = req_err;
         we_d  = wb_we_i;
         if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
         end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         we_q    <= we_d;
      end
   end

   wb_data_ram_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (AW)
   ) u_array (
      .clk     (wb_clk_i),
      .en_i    (accept && !req_err),
      .we_i    (wb_we_i),
      .sel_i   (wb_sel_i),
      .addr_i  (offset[AW+1:2]),
      .wdata_i (wb_dat_i),
      .rdata_o (rdata)
   );

   assign wb_stall_o = (state_q == ST_WAIT);
   assign wb_ack_o   = (state_q == ST_RESP) && !err_q;
   assign wb_err_o   = (state_q == ST_RESP) && err_q;
   assign wb_dat_o   = (wb_ack_o && !we_q) ? rdata : '0;

endmodule

// File: tb/tb_wb_data_ram.sv
// tb/tb_wb_data_ram.sv - directed bench for wb_data_ram (zero and three wait-state instances)
module tb_wb_data_ram;

   logic        clk = 1'b0;
   logic        rst, cyc_any, stb, we, use3;
   logic [31:0] adr, dat;
   logic [3:0]  sel;
   logic        cyc0, cyc3;
   logic        stall0, ack0, err0, stall3, ack3, err3;
   logic [31:0] dat0, dat3;
   logic        s_stall, s_ack, s_err;
   logic [31:0] s_dat;
   logic        stall0_seen;
   int          n_cmp, n_bad;

   always #5 clk = ~clk;

   assign cyc0 = cyc_any & ~use3;
   assign cyc3 = cyc_any & use3;

   wb_data_ram #(
      .BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_STATES(0), .PROTECT_TOP(32'h0)
   ) dut0 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc0), .wb_stb_i(stb),
      .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
      .wb_stall_o(stall0), .wb_ack_o(ack0), .wb_dat_o(dat0), .wb_err_o(err0)
   );

   wb_data_ram #(
      .BASE_ADDR(32'h0), .DEPTH(1024), .WAIT_STATES(3), .PROTECT_TOP(32'h100)
   ) dut3 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc3), .wb_stb_i(stb),
      .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
      .wb_stall_o(stall3), .wb_ack_o(ack3), .wb_dat_o(dat3), .wb_err_o(err3)
   );

   always_comb begin
      s_stall = use3 ? stall3 : stall0;
      s_ack   = use3 ? ack3   : ack0;
      s_err   = use3 ? err3   : err0;
      s_dat   = use3 ? dat3   : dat0;
   end

   always @(negedge clk) begin
      if (!rst && stall0) stall0_seen <= 1'b1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts and ends on a negedge; returns response flags, read data and cycles from acceptance.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic g_ack, output logic g_err, output logic [31:0] g_dat, output int lat);
      cyc_any = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
      for (int i = 0; i < 20 && s_stall; i++) @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      stb = 1'b0;
      lat = 1;
      while (!s_ack && !s_err && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      g_ack = s_ack; g_err = s_err; g_dat = s_dat;
      @(negedge clk);
      cyc_any = 1'b0;
      @(negedge clk);
   endtask

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        ack;
      logic        err;
      logic [31:0] rdat;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl [NV];

   initial begin
      logic        g_ack, g_err, flag;
      logic [31:0] g_dat, old;
      int          lat;

      tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF};
      tbl[2]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0};
      tbl[3]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'h5, 1'b1, 1'b0, 32'h0};
      tbl[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b1, 1'b0, 32'hFF22_FF44};
      tbl[5]  = '{1'b1, 32'h0000_0024, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 32'h0};
      tbl[6]  = '{1'b1, 32'h0000_0024, 32'hA5A5_A5A5, 4'h0, 1'b1, 1'b0, 32'h0};
      tbl[7]  = '{1'b0, 32'h0000_0024, 32'h0,         4'hF, 1'b1, 1'b0, 32'h1234_5678};
      tbl[8]  = '{1'b1, 32'h0000_0028, 32'h0000_0000, 4'hF, 1'b1, 1'b0, 32'h0};
      tbl[9]  = '{1'b1, 32'h0000_0028, 32'hAABB_CCDD, 4'hA, 1'b1, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 32'h0000_0028, 32'h0,         4'hF, 1'b1, 1'b0, 32'hAA00_CC00};
      tbl[11] = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
      tbl[12] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 32'h0000_0FFE, 32'h0,         4'hF, 1'b1, 1'b0, 32'hCAFE_F00D};
      tbl[14] = '{1'b1, 32'h0000_1000, 32'h0BAD_0BAD, 4'hF, 1'b0, 1'b1, 32'h0};
      tbl[15] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0};
      tbl[16] = '{1'b1, 32'h0000_1010, 32'h0000_0000, 4'hF, 1'b0, 1'b1, 32'h0};
      tbl[17] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b1, 1'b0, 32'hDEAD_BEEF};

      n_cmp = 0; n_bad = 0; stall0_seen = 1'b0;
      rst = 1'b1; cyc_any = 1'b0; stb = 1'b0; we = 1'b0; use3 = 1'b0;
      adr = '0; dat = '0; sel = '0;
      repeat (3) @(negedge clk);
      chk("reset outs dut0", {28'h0, stall0, ack0, err0, |dat0}, 32'h0);
      chk("reset outs dut3", {28'h0, stall3, ack3, err3, |dat3}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         xfer(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, g_ack, g_err, g_dat, lat);
         chk($sformatf("vec%0d ack", i), 32'(g_ack), 32'(tbl[i].ack));
         chk($sformatf("vec%0d err", i), 32'(g_err), 32'(tbl[i].err));
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
         if (!tbl[i].we || tbl[i].err) chk($sformatf("vec%0d rdata", i), g_dat, tbl[i].rdat);
      end

      // Back-to-back: read taken in the write's ack cycle sees the new word
      cyc_any = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h30; dat = 32'h0BAD_F00D; sel = 4'hF;
      @(negedge clk);
      chk("b2b write ack", 32'(s_ack), 32'd1);
      we = 1'b0;
      @(negedge clk);
      chk("b2b read ack", 32'(s_ack), 32'd1);
      chk("b2b read data", s_dat, 32'h0BAD_F00D);
      stb = 1'b0; cyc_any = 1'b0;
      @(negedge clk);
      chk("b2b idle ack", 32'(s_ack), 32'd0);
      chk("ws0 stall never seen", 32'(stall0_seen), 32'd0);

      use3 = 1'b1;
      xfer(1'b1, 32'h140, 32'h55AA_55AA, 4'hF, g_ack, g_err, g_dat, lat);
      chk("ws3 write ack", 32'(g_ack), 32'd1);
      chk("ws3 write latency", 32'(lat), 32'd4);
      xfer(1'b1, 32'h144, 32'h6677_8899, 4'hF, g_ack, g_err, g_dat, lat);
      chk("ws3 write2 ack", 32'(g_ack), 32'd1);

      // Wait-state pipeline: second request stalls until the first ack cycle
      cyc_any = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h140; sel = 4'hF;
      @(negedge clk); stb = 1'b0;
      chk("ws3 stall t+1", 32'(s_stall), 32'd1);
      @(negedge clk); stb = 1'b1; adr = 32'h144;
      chk("ws3 stall t+2", 32'(s_stall), 32'd1);
      @(negedge clk);
      chk("ws3 stall t+3", 32'(s_stall), 32'd1);
      chk("ws3 no early ack", 32'(s_ack), 32'd0);
      @(negedge clk);
      chk("ws3 ack t+4", 32'(s_ack), 32'd1);
      chk("ws3 stall t+4", 32'(s_stall), 32'd0);
      chk("ws3 data t+4", s_dat, 32'h55AA_55AA);
      @(negedge clk); stb = 1'b0;
      chk("ws3 second accepted", 32'(s_stall), 32'd1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("ws3 second ack", 32'(s_ack), 32'd1);
      chk("ws3 second data", s_dat, 32'h6677_8899);
      cyc_any = 1'b0;
      @(negedge clk);

      xfer(1'b0, 32'h1000, 32'h0, 4'hF, g_ack, g_err, g_dat, lat);
      chk("ws3 oor err", 32'(g_err), 32'd1);
      chk("ws3 oor no ack", 32'(g_ack), 32'd0);
      chk("ws3 oor latency", 32'(lat), 32'd4);
      chk("ws3 oor data", g_dat, 32'h0);

      // Abort by dropping cyc during WAIT
      cyc_any = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h140;
      @(negedge clk); stb = 1'b0;
      @(negedge clk); cyc_any = 1'b0;
      chk("abort stall t+2", 32'(s_stall), 32'd1);
      @(negedge clk);
      chk("abort idle t+3", 32'(s_stall), 32'd0);
      flag = 1'b0;
      for (int i = 0; i < 5; i++) begin
         flag = flag | s_ack | s_err;
         @(negedge clk);
      end
      chk("abort no response", 32'(flag), 32'd0);

      cyc_any = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h148; dat = 32'h1357_9BDF;
      @(negedge clk); stb = 1'b0; cyc_any = 1'b0;
      @(negedge clk);
      xfer(1'b0, 32'h148, 32'h0, 4'hF, g_ack, g_err, g_dat, lat);
      chk("aborted write kept", g_dat, 32'h1357_9BDF);

      // Reset during WAIT
      cyc_any = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h140;
      @(negedge clk); stb = 1'b0;
      chk("rst pre stall", 32'(s_stall), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst outs", {28'h0, stall3, ack3, err3, |dat3}, 32'h0);
      rst = 1'b0; cyc_any = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         flag = flag | s_ack | s_err;
      end
      chk("rst response discarded", 32'(flag), 32'd0);
      xfer(1'b0, 32'h140, 32'h0, 4'hF, g_ack, g_err, g_dat, lat);
      chk("ram survives reset", g_dat, 32'h55AA_55AA);

`ifdef WB_RAM_WPROT_EN
      xfer(1'b0, 32'h80, 32'h0, 4'hF, g_ack, g_err, g_dat, lat);
      chk("wprot pre read ack", 32'(g_ack), 32'd1);
      old = g_dat;
      xfer(1'b1, 32'h80, ~old, 4'hF, g_ack, g_err, g_dat, lat);
      chk("wprot write err", 32'(g_err), 32'd1);
      chk("wprot write no ack", 32'(g_ack), 32'd0);
      chk("wprot err latency", 32'(lat), 32'd4);
      xfer(1'b1, 32'h100, 32'h0F0F_0F0F, 4'hF, g_ack, g_err, g_dat, lat);
      chk("wprot edge write ack", 32'(g_ack), 32'd1);
      xfer(1'b0, 32'h80, 32'h0, 4'hF, g_ack, g_err, g_dat, lat);
      chk("wprot read ack", 32'(g_ack), 32'd1);
      chk("wprot mem unchanged", g_dat, old);
      xfer(1'b0, 32'h100, 32'h0, 4'hF, g_ack, g_err, g_dat, lat);
      chk("wprot edge read", g_dat, 32'h0F0F_0F0F);
`else
      old = 32'h2468_1357;
      xfer(1'b1, 32'h80, old, 4'hF, g_ack, g_err, g_dat, lat);
      chk("noprot write ack", 32'(g_ack), 32'd1);
      chk("noprot write no err", 32'(g_err), 32'd0);
      xfer(1'b0, 32'h80, 32'h0, 4'hF, g_ack, g_err, g_dat, lat);
      chk("noprot read back", g_dat, 32'h2468_1357);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
